// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg
//   Shared constants for the SPI burst sequencer: spi_controller register
//   addresses, CPU register window addresses, CMD/STATUS bit positions and
//   the burst engine state enum.
//   No ports (package).
package spi_seq_pkg;

  // spi_controller register port map
  localparam logic [1:0] CTL_ADDR_RX   = 2'd1;
  localparam logic [1:0] CTL_ADDR_TX   = 2'd2;
  localparam logic [1:0] CTL_ADDR_CTRL = 2'd3;
  localparam int         CTL_BUSY_BIT  = 7;

  // CPU register window map
  localparam logic [1:0] CPU_ADDR_FIFO = 2'd0;
  localparam logic [1:0] CPU_ADDR_LEN  = 2'd1;
  localparam logic [1:0] CPU_ADDR_CMD  = 2'd2;
  localparam logic [1:0] CPU_ADDR_RSVD = 2'd3;

  // CMD write bits
  localparam int CMD_START_BIT   = 0;
  localparam int CMD_KEEP_CS_BIT = 1;
  localparam int CMD_FLUSH_BIT   = 2;
  localparam int CMD_IRQ_EN_BIT  = 3;

  // STATUS read bits
  localparam int ST_BUSY_BIT     = 7;
  localparam int ST_TX_FULL_BIT  = 6;
  localparam int ST_TX_EMPTY_BIT = 5;
  localparam int ST_RX_FULL_BIT  = 4;
  localparam int ST_RX_EMPTY_BIT = 3;
  localparam int ST_DONE_BIT     = 1;
  localparam int ST_OVF_BIT      = 0;

  // Burst engine states
  typedef enum logic [2:0] {
    IDLE,
    CSON,
    LOAD,
    POLL,
    RXRD,
    CSOFF,
    DONE
  } seqState_e;

endpackage

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo
//   Synchronous 8-bit FIFO used for both the TX and RX byte queues.
//   A push on a full FIFO is accepted when a pop happens in the same cycle,
//   so a full FIFO can be drained and refilled without losing a byte.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush_i          empties the FIFO (wins over push/pop)
//   push_i/pushData_i  write request and data
//   pop_i/popData_o  read request, head-of-queue data (valid when !empty_o)
//   full_o, empty_o  occupancy flags
module spi_seq_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] pushData_i,
  input  logic       pop_i,
  output logic [7:0] popData_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush;
  logic          doPop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == '0);
  assign doPop     = pop_i && !empty_o;
  assign doPush    = push_i && (!full_o || pop_i);
  assign popData_o = mem_q[rdPtr_q];

  // Pointer and occupancy bookkeeping; flush simply rewinds everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer
//   Autonomous multi-byte SPI burst engine between the CPU register bus and
//   spi_controller. The CPU queues TX bytes, sets a length and starts a
//   burst; the engine asserts SPI CS, sends one byte per transfer, polls the
//   controller busy flag and collects received bytes into the RX FIFO.
//   Optional macro SPI_SEQ_IRQ_EN adds o_irq and CMD bit3 irq_en.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_cs/i_rwb/i_addr/i_data CPU register access (0 FIFO, 1 LEN, 2 CMD/STATUS, 3 rsvd)
//   o_data                  CPU read data, combinational from i_addr
//   o_ctl_*                 registered spi_controller register port
//   i_ctl_data              spi_controller read data
//   o_irq                   (SPI_SEQ_IRQ_EN only) done & irq_en, registered
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cs,
  input  logic       i_rwb,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_ctl_cs,
  output logic       o_ctl_rwb,
  output logic [1:0] o_ctl_addr,
  output logic [7:0] o_ctl_data,
`ifdef SPI_SEQ_IRQ_EN
  output logic       o_irq,
`endif
  input  logic [7:0] i_ctl_data
);

  seqState_e  state_q, state_d;
  logic       phase_q, phase_d;
  logic       ctlCs_q, ctlCs_d;
  logic       ctlRwb_q, ctlRwb_d;
  logic [1:0] ctlAddr_q, ctlAddr_d;
  logic [7:0] ctlData_q, ctlData_d;
  logic [7:0] remain_q;
  logic       keepCs_q;
  logic       done_q, done_d;
  logic       ovf_q;

  logic       busy;
  logic       cpuWr, cpuRd;
  logic       txPushCpu, rxPopCpu, lenWr, cmdWr, startAcc, flush, statusRd;
  logic       txPopEng, rxPushEng, remainDec, setDone;
  logic       txFull, txEmpty, rxFull, rxEmpty;
  logic [7:0] txHead, rxHead;
  logic [7:0] status;

  // CPU register decode. Start, LEN and keep_cs are locked while a burst
  // runs; FIFO traffic and flush are always honoured.
  assign busy      = (state_q != IDLE);
  assign cpuWr     = i_cs && !i_rwb;
  assign cpuRd     = i_cs && i_rwb;
  assign txPushCpu = cpuWr && (i_addr == CPU_ADDR_FIFO);
  assign rxPopCpu  = cpuRd && (i_addr == CPU_ADDR_FIFO);
  assign lenWr     = cpuWr && (i_addr == CPU_ADDR_LEN) && !busy;
  assign cmdWr     = cpuWr && (i_addr == CPU_ADDR_CMD);
  assign startAcc  = cmdWr && i_data[CMD_START_BIT] && !busy;
  assign flush     = cmdWr && i_data[CMD_FLUSH_BIT];
  assign statusRd  = cpuRd && (i_addr == CPU_ADDR_CMD);

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) txFifo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .flush_i    (flush),
    .push_i     (txPushCpu),
    .pushData_i (i_data),
    .pop_i      (txPopEng),
    .popData_o  (txHead),
    .full_o     (txFull),
    .empty_o    (txEmpty)
  );

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .flush_i    (flush),
    .push_i     (rxPushEng),
    .pushData_i (i_ctl_data),
    .pop_i      (rxPopCpu),
    .popData_o  (rxHead),
    .full_o     (rxFull),
    .empty_o    (rxEmpty)
  );

  // Burst engine next state. Every controller access state has two phases:
  // phase 0 loads the strobe into the output registers, phase 1 is the
  // strobe cycle itself (read data is valid on i_ctl_data) while the output
  // registers are loaded with the gap. The following state's phase 0 is
  // therefore the gap cycle, giving a 2-cycle access.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ctlCs_d   = 1'b0;
    ctlRwb_d  = 1'b1;
    ctlAddr_d = ctlAddr_q;
    ctlData_d = ctlData_q;
    txPopEng  = 1'b0;
    rxPushEng = 1'b0;
    remainDec = 1'b0;
    setDone   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startAcc) begin
          if (remain_q != 8'd0) begin
            state_d = CSON;
            phase_d = 1'b0;
          end else begin
            setDone = 1'b1;
          end
        end
      end
      CSON: begin
        if (!phase_q) begin
          ctlCs_d   = 1'b1;
          ctlRwb_d  = 1'b0;
          ctlAddr_d = CTL_ADDR_CTRL;
          ctlData_d = 8'h01;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!phase_q) begin
          ctlCs_d   = 1'b1;
          ctlRwb_d  = 1'b0;
          ctlAddr_d = CTL_ADDR_TX;
          ctlData_d = txEmpty ? FILL_BYTE : txHead;
          txPopEng  = !txEmpty;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = POLL;
        end
      end
      POLL: begin
        if (!phase_q) begin
          ctlCs_d   = 1'b1;
          ctlAddr_d = CTL_ADDR_CTRL;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = i_ctl_data[CTL_BUSY_BIT] ? POLL : RXRD;
        end
      end
      RXRD: begin
        if (!phase_q) begin
          ctlCs_d   = 1'b1;
          ctlAddr_d = CTL_ADDR_RX;
          phase_d   = 1'b1;
        end else begin
          phase_d   = 1'b0;
          rxPushEng = 1'b1;
          remainDec = 1'b1;
          if (remain_q != 8'd1) state_d = LOAD;
          else if (keepCs_q)    state_d = DONE;
          else                  state_d = CSOFF;
        end
      end
      CSOFF: begin
        if (!phase_q) begin
          ctlCs_d   = 1'b1;
          ctlRwb_d  = 1'b0;
          ctlAddr_d = CTL_ADDR_CTRL;
          ctlData_d = 8'h00;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        setDone = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // done is sticky; a completion in the same cycle as a STATUS read wins so
  // that it is never lost.
  always_comb begin
    done_d = done_q;
    if (setDone)       done_d = 1'b1;
    else if (statusRd) done_d = 1'b0;
  end

  // Engine and controller-port registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      ctlCs_q   <= 1'b0;
      ctlRwb_q  <= 1'b1;
      ctlAddr_q <= 2'd0;
      ctlData_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ctlCs_q   <= ctlCs_d;
      ctlRwb_q  <= ctlRwb_d;
      ctlAddr_q <= ctlAddr_d;
      ctlData_q <= ctlData_d;
    end
  end

  // CPU-visible control state: remaining count, keep_cs, done and overflow.
  // An RX push into a full FIFO only overflows when the CPU is not popping
  // the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remain_q <= 8'd0;
      keepCs_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (remainDec)  remain_q <= remain_q - 8'd1;
      else if (lenWr) remain_q <= i_data;
      if (cmdWr && !busy) keepCs_q <= i_data[CMD_KEEP_CS_BIT];
      done_q <= done_d;
      if (flush)                                   ovf_q <= 1'b0;
      else if (rxPushEng && rxFull && !rxPopCpu)   ovf_q <= 1'b1;
    end
  end

`ifdef SPI_SEQ_IRQ_EN
  logic irqEn_q, irqEn_d, irq_q;

  // The interrupt tracks next-cycle done and irq_en so it drops together
  // with done after the clearing STATUS read.
  assign irqEn_d = cmdWr ? i_data[CMD_IRQ_EN_BIT] : irqEn_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irqEn_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irqEn_q <= irqEn_d;
      irq_q   <= done_d && irqEn_d;
    end
  end

  assign o_irq = irq_q;
`endif

  // CPU read mux; an empty RX FIFO reads as zero.
  always_comb begin
    status                  = 8'h00;
    status[ST_BUSY_BIT]     = busy;
    status[ST_TX_FULL_BIT]  = txFull;
    status[ST_TX_EMPTY_BIT] = txEmpty;
    status[ST_RX_FULL_BIT]  = rxFull;
    status[ST_RX_EMPTY_BIT] = rxEmpty;
    status[ST_DONE_BIT]     = done_q;
    status[ST_OVF_BIT]      = ovf_q;
    unique case (i_addr)
      CPU_ADDR_FIFO: o_data = rxEmpty ? 8'h00 : rxHead;
      CPU_ADDR_LEN:  o_data = remain_q;
      CPU_ADDR_CMD:  o_data = status;
      CPU_ADDR_RSVD: o_data = 8'h00;
      default:       o_data = 8'h00;
    endcase
  end

  assign o_ctl_cs   = ctlCs_q;
  assign o_ctl_rwb  = ctlRwb_q;
  assign o_ctl_addr = ctlAddr_q;
  assign o_ctl_data = ctlData_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb_spi_burst_sequencer
//   Self-checking bench for spi_burst_sequencer: a table of CPU register
//   vectors followed by hand-written burst sequences against a small
//   spi_controller model that logs every register access.
//   Exercises o_irq when built with SPI_SEQ_IRQ_EN.
module tb_spi_burst_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cs = 1'b0;
  logic       i_rwb = 1'b1;
  logic [1:0] i_addr = 2'd0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] o_data;
  logic       o_ctl_cs;
  logic       o_ctl_rwb;
  logic [1:0] o_ctl_addr;
  logic [7:0] o_ctl_data;
  logic [7:0] i_ctl_data;
`ifdef SPI_SEQ_IRQ_EN
  logic       o_irq;
`endif

  spi_burst_sequencer #(.FIFO_DEPTH(8), .FILL_BYTE(8'hFF)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cs       (i_cs),
    .i_rwb      (i_rwb),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_ctl_cs   (o_ctl_cs),
    .o_ctl_rwb  (o_ctl_rwb),
    .o_ctl_addr (o_ctl_addr),
    .o_ctl_data (o_ctl_data),
`ifdef SPI_SEQ_IRQ_EN
    .o_irq      (o_irq),
`endif
    .i_ctl_data (i_ctl_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       chk;
    logic [7:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic       rwb;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  int   checks = 0;
  int   passes = 0;
  vec_t vecs[$];
  acc_t expQ[$];

  // spi_controller model: busy for pollBusy status reads after each TX
  // write, RX register returns rxVal, every strobe is logged.
  int         pollBusy = 0;
  logic [7:0] rxVal = 8'h00;
  int         busyCnt = 0;
  int         logCount = 0;
  logic       logRwb [0:511];
  logic [1:0] logAddr [0:511];
  logic [7:0] logData [0:511];

  always_comb begin
    i_ctl_data = 8'h00;
    if (o_ctl_addr == 2'd3)      i_ctl_data = (busyCnt != 0) ? 8'h80 : 8'h00;
    else if (o_ctl_addr == 2'd1) i_ctl_data = rxVal;
  end

  always @(posedge i_clk) begin
    if (o_ctl_cs && logCount < 512) begin
      logRwb[logCount]  <= o_ctl_rwb;
      logAddr[logCount] <= o_ctl_addr;
      logData[logCount] <= o_ctl_data;
      logCount <= logCount + 1;
      if (!o_ctl_rwb && o_ctl_addr == 2'd2)
        busyCnt <= pollBusy;
      else if (o_ctl_rwb && o_ctl_addr == 2'd3 && busyCnt > 0)
        busyCnt <= busyCnt - 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic cpuCycle(input logic wr, input logic [1:0] addr,
                          input logic [7:0] wdata, output logic [7:0] rdata);
    @(negedge i_clk);
    i_cs = 1'b1;
    i_rwb = !wr;
    i_addr = addr;
    i_data = wdata;
    #1 rdata = o_data;
    @(posedge i_clk);
    #1;
    i_cs = 1'b0;
    i_rwb = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] rd;
    cpuCycle(v.wr, v.addr, v.wdata, rd);
    if (v.chk) checkOutput(v.name, rd, v.exp);
  endtask

  task automatic cpuWrite(input logic [1:0] addr, input logic [7:0] wdata);
    logic [7:0] rd;
    cpuCycle(1'b1, addr, wdata, rd);
  endtask

  task automatic cpuReadCheck(input string name, input logic [1:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    cpuCycle(1'b0, addr, 8'h00, rd);
    checkOutput(name, rd, exp);
  endtask

  // Side-effect-free STATUS peek (i_cs low, o_data is combinational).
  task automatic peekStatus(output logic [7:0] st);
    @(negedge i_clk);
    i_cs = 1'b0;
    i_addr = 2'd2;
    #1 st = o_data;
  endtask

  task automatic waitIdle(input string name);
    logic [7:0] st;
    int n;
    st = 8'h80;
    for (n = 0; n < 2000 && st[7]; n++) peekStatus(st);
    checkOutput(name, st[7], 0);
  endtask

  // Expected controller accesses for one burst.
  task automatic buildBurst(input logic [7:0] bytes[$], input int polls, input logic keep);
    expQ.delete();
    expQ.push_back('{1'b0, 2'd3, 8'h01});
    foreach (bytes[i]) begin
      expQ.push_back('{1'b0, 2'd2, bytes[i]});
      for (int p = 0; p <= polls; p++) expQ.push_back('{1'b1, 2'd3, 8'h00});
      expQ.push_back('{1'b1, 2'd1, 8'h00});
    end
    if (!keep) expQ.push_back('{1'b0, 2'd3, 8'h00});
  endtask

  task automatic compareLog(input string name, input int base);
    int act, exp;
    checkOutput({name, "_count"}, logCount - base, expQ.size());
    foreach (expQ[i]) begin
      exp = {expQ[i].rwb, expQ[i].addr, expQ[i].rwb ? 8'h00 : expQ[i].data};
      if (base + i < logCount)
        act = {logRwb[base+i], logAddr[base+i], logRwb[base+i] ? 8'h00 : logData[base+i]};
      else
        act = -1;
      checkOutput($sformatf("%s_acc%0d", name, i), act, exp);
    end
  endtask

  initial begin
    int base, snap, n;
    logic [7:0] st;
    logic [7:0] bytes[$];

    // Register-level vectors: {wr, addr, wdata, chk, exp, name}
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 8'h28, "rst_status"});
    vecs.push_back('{1'b0, 2'd1, 8'h00, 1'b1, 8'h00, "rst_len"});
    vecs.push_back('{1'b0, 2'd3, 8'h00, 1'b1, 8'h00, "rsvd_read"});
    vecs.push_back('{1'b0, 2'd0, 8'h00, 1'b1, 8'h00, "rx_empty_pop"});
    vecs.push_back('{1'b1, 2'd3, 8'h55, 1'b0, 8'h00, "rsvd_write"});
    vecs.push_back('{1'b0, 2'd3, 8'h00, 1'b1, 8'h00, "rsvd_after_write"});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 8'h00, "len0"});
    vecs.push_back('{1'b1, 2'd2, 8'h01, 1'b0, 8'h00, "start_len0"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 8'h2A, "len0_done"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 8'h28, "done_cleared"});
    vecs.push_back('{1'b1, 2'd1, 8'h05, 1'b0, 8'h00, "len5"});
    vecs.push_back('{1'b0, 2'd1, 8'h00, 1'b1, 8'h05, "len_readback"});
    vecs.push_back('{1'b1, 2'd0, 8'hAA, 1'b0, 8'h00, "push_aa"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 8'h08, "tx_not_empty"});
    vecs.push_back('{1'b1, 2'd2, 8'h04, 1'b0, 8'h00, "flush1"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 8'h28, "flush_tx"});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 2'd0, 8'(i + 1), 1'b0, 8'h00, "fill_tx"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 8'h48, "tx_full"});
    vecs.push_back('{1'b1, 2'd2, 8'h04, 1'b0, 8'h00, "flush2"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 8'h28, "flush_full"});

    // Reset state of the controller port
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_ctl_cs", o_ctl_cs, 0);
    checkOutput("rst_ctl_rwb", o_ctl_rwb, 1);
    checkOutput("rst_ctl_addr", o_ctl_addr, 0);
    checkOutput("rst_ctl_data", o_ctl_data, 0);
    i_rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Basic two-byte burst with three busy polls per byte
    pollBusy = 3;
    rxVal = 8'h55;
    base = logCount;
    cpuWrite(2'd0, 8'hAA);
    cpuWrite(2'd0, 8'h01);
    cpuWrite(2'd1, 8'h02);
    cpuWrite(2'd2, 8'h01);
    peekStatus(st);
    checkOutput("a_busy", st[7], 1);
    waitIdle("a_finish");
    bytes = '{8'hAA, 8'h01};
    buildBurst(bytes, 3, 1'b0);
    compareLog("a", base);
    cpuReadCheck("a_status", 2'd2, 8'h22);
    cpuReadCheck("a_pop0", 2'd0, 8'h55);
    cpuReadCheck("a_pop1", 2'd0, 8'h55);
    cpuReadCheck("a_rx_empty", 2'd2, 8'h28);

    // Empty TX FIFO, keep_cs: fill bytes and no CS release
    pollBusy = 1;
    rxVal = 8'h3C;
    base = logCount;
    cpuWrite(2'd1, 8'h03);
    cpuWrite(2'd2, 8'h03);
    waitIdle("b_finish");
    bytes = '{8'hFF, 8'hFF, 8'hFF};
    buildBurst(bytes, 1, 1'b1);
    compareLog("b", base);
    cpuReadCheck("b_status", 2'd2, 8'h22);
    cpuWrite(2'd2, 8'h04);

    // RX overflow: 10 bytes into an 8-deep FIFO
    pollBusy = 0;
    rxVal = 8'hC3;
    cpuWrite(2'd1, 8'd10);
    cpuWrite(2'd2, 8'h01);
    waitIdle("c_finish");
    cpuReadCheck("c_status", 2'd2, 8'h33);
    cpuReadCheck("c_remaining", 2'd1, 8'h00);
    for (int i = 0; i < 8; i++) cpuReadCheck($sformatf("c_pop%0d", i), 2'd0, 8'hC3);
    cpuReadCheck("c_ovf_sticky", 2'd2, 8'h29);
    cpuWrite(2'd2, 8'h04);
    cpuReadCheck("c_flush", 2'd2, 8'h28);

    // Start and LEN writes while busy are ignored
    pollBusy = 3;
    rxVal = 8'h11;
    base = logCount;
    cpuWrite(2'd1, 8'h02);
    cpuWrite(2'd2, 8'h01);
    cpuWrite(2'd1, 8'h07);
    cpuWrite(2'd2, 8'h01);
    cpuReadCheck("d_remaining_mid", 2'd1, 8'h02);
    waitIdle("d_finish");
    bytes = '{8'hFF, 8'hFF};
    buildBurst(bytes, 3, 1'b0);
    compareLog("d", base);
    cpuReadCheck("d_status", 2'd2, 8'h22);
    cpuReadCheck("d_remaining_end", 2'd1, 8'h00);
    snap = logCount;
    repeat (10) @(posedge i_clk);
    #1;
    checkOutput("d_no_restart", logCount, snap);
    cpuWrite(2'd2, 8'h04);

    // Reset during POLL, then a clean burst
    pollBusy = 20;
    base = logCount;
    cpuWrite(2'd0, 8'h12);
    cpuWrite(2'd0, 8'h34);
    cpuWrite(2'd1, 8'h02);
    cpuWrite(2'd2, 8'h01);
    for (n = 0; n < 200 && logCount < base + 3; n++) @(negedge i_clk);
    checkOutput("e_reached_poll", logCount >= base + 3, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("e_rst_ctl_cs", o_ctl_cs, 0);
    checkOutput("e_rst_ctl_rwb", o_ctl_rwb, 1);
    i_addr = 2'd2;
    #1;
    checkOutput("e_rst_status", o_data, 8'h28);
    snap = logCount;
    i_rst = 1'b0;
    repeat (6) @(negedge i_clk);
    checkOutput("e_no_cs_write", logCount, snap);
    pollBusy = 0;
    rxVal = 8'h77;
    base = logCount;
    cpuWrite(2'd1, 8'h01);
    cpuWrite(2'd2, 8'h01);
    waitIdle("e_finish");
    bytes = '{8'hFF};
    buildBurst(bytes, 0, 1'b0);
    compareLog("e", base);
    cpuReadCheck("e_status", 2'd2, 8'h22);
    cpuReadCheck("e_pop", 2'd0, 8'h77);

`ifdef SPI_SEQ_IRQ_EN
    // Interrupt follows done while irq_en is set
    cpuWrite(2'd1, 8'h01);
    cpuWrite(2'd2, 8'h09);
    waitIdle("f_finish");
    @(negedge i_clk);
    checkOutput("f_irq_high", o_irq, 1);
    cpuReadCheck("f_status", 2'd2, 8'h22);
    checkOutput("f_irq_low", o_irq, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
